// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_mc #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned DEFAULT_RESULT = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_operation,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             ovf,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_SLT  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] qr;
   logic [WIDTH-1:0] br;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] iter_acc;
   logic [WIDTH-1:0] iter_q;
   logic [WIDTH-1:0] iter_b;
   logic             do_mul;
   logic             do_div;
   logic [WIDTH:0]   add_x;
   logic [WIDTH:0]   add_y;
   logic             add_sub;
   logic [WIDTH+1:0] add_sum;

   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic             no_borrow;
   logic [WIDTH-1:0] div_rem;
   logic [WIDTH-1:0] div_q;

   logic [CW-1:0]    shamt;
   logic             is_multi;
   logic [WIDTH-1:0] sc_lo;
   logic [WIDTH-1:0] sc_hi;
   logic             sc_ovf;
   logic             sc_dbz;

   // The first iteration runs on the start edge straight from the inputs
   always_comb begin
      iter_acc = (state == S_IDLE) ? '0   : acc;
      iter_q   = (state == S_IDLE) ? in_a : qr;
      iter_b   = (state == S_IDLE) ? in_b : br;
      do_mul   = (state == S_MUL) || ((state == S_IDLE) && (alu_operation == OP_MUL));
      do_div   = (state == S_DIV) || ((state == S_IDLE) && (alu_operation == OP_DIVU));
   end

   // Single shared WIDTH+1 adder/subtractor; the extra carry bit flags no-borrow
   always_comb begin
      add_x   = {1'b0, in_a};
      add_y   = {1'b0, in_b};
      add_sub = (alu_operation == OP_SUB);
      if (do_mul) begin
         add_x   = {1'b0, iter_acc};
         add_y   = iter_q[0] ? {1'b0, iter_b} : '0;
         add_sub = 1'b0;
      end else if (do_div) begin
         add_x   = {iter_acc, iter_q[WIDTH-1]};
         add_y   = {1'b0, iter_b};
         add_sub = 1'b1;
      end
   end

   assign add_sum = {1'b0, add_x} + {1'b0, add_y ^ {(WIDTH+1){add_sub}}} + (WIDTH+2)'(add_sub);

   assign mul_hi    = add_sum[WIDTH:1];
   assign mul_lo    = {add_sum[0], iter_q[WIDTH-1:1]};
   assign no_borrow = add_sum[WIDTH+1];
   assign div_rem   = no_borrow ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
   assign div_q     = {iter_q[WIDTH-2:0], no_borrow};

   assign shamt    = in_b[CW-1:0];
   assign is_multi = (alu_operation == OP_MUL) ||
                     ((alu_operation == OP_DIVU) && (in_b != '0));

   // Single-cycle result selection
   always_comb begin
      sc_lo  = '0;
      sc_hi  = '0;
      sc_ovf = 1'b0;
      sc_dbz = 1'b0;
      case (alu_operation)
         OP_AND: sc_lo = in_a & in_b;
         OP_OR:  sc_lo = in_a | in_b;
         OP_ADD: begin
            sc_lo  = add_sum[WIDTH-1:0];
            sc_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sc_lo[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_lo  = add_sum[WIDTH-1:0];
            sc_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sc_lo[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_SLT: sc_lo = WIDTH'($signed(in_a) < $signed(in_b));
         OP_SLL: sc_lo = in_a << shamt;
         OP_SRL: sc_lo = in_a >> shamt;
         OP_SRA: sc_lo = WIDTH'($signed(in_a) >>> shamt);
         OP_MUL: sc_lo = '0;
         OP_DIVU: begin
            sc_lo  = '1;
            sc_hi  = in_a;
            sc_dbz = 1'b1;
         end
         default: sc_lo = WIDTH'(DEFAULT_RESULT);
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         acc         <= '0;
         qr          <= '0;
         br          <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result_lo   <= '0;
         result_hi   <= '0;
         zero        <= 1'b1;
         ovf         <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (is_multi) begin
                     acc   <= (alu_operation == OP_MUL) ? mul_hi : div_rem;
                     qr    <= (alu_operation == OP_MUL) ? mul_lo : div_q;
                     br    <= in_b;
                     cnt   <= CW'(1);
                     busy  <= 1'b1;
                     state <= (alu_operation == OP_MUL) ? S_MUL : S_DIV;
                  end else begin
                     result_lo   <= sc_lo;
                     result_hi   <= sc_hi;
                     zero        <= (sc_lo == '0);
                     ovf         <= sc_ovf;
                     div_by_zero <= sc_dbz;
                     done        <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               acc <= mul_hi;
               qr  <= mul_lo;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH-1)) begin
                  result_lo   <= mul_lo;
                  result_hi   <= mul_hi;
                  zero        <= (mul_lo == '0);
                  ovf         <= 1'b0;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            S_DIV: begin
               acc <= div_rem;
               qr  <= div_q;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH-1)) begin
                  result_lo   <= div_q;
                  result_hi   <= div_rem;
                  zero        <= (div_q == '0);
                  ovf         <= 1'b0;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: vector table for single-cycle ops, hand sequences
// for multiply/divide latency, busy behaviour, mid-operation reset and back-to-back.
module tb_alu_mc;

   localparam logic [3:0] OP_AND  = 4'h0;
   localparam logic [3:0] OP_OR   = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_SLT  = 4'h4;
   localparam logic [3:0] OP_SLL  = 4'h5;
   localparam logic [3:0] OP_SRL  = 4'h6;
   localparam logic [3:0] OP_SRA  = 4'h7;
   localparam logic [3:0] OP_MUL  = 4'h8;
   localparam logic [3:0] OP_DIVU = 4'h9;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        busy, done, zero, ovf, dbz;
   logic [31:0] lo, hi;

   logic        start8;
   logic [3:0]  op8;
   logic [7:0]  a8, b8;
   logic        busy8, done8, zero8, ovf8, dbz8;
   logic [7:0]  lo8, hi8;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(32), .DEFAULT_RESULT(1000)) dut (
      .clk(clk), .rst(rst), .start(start), .alu_operation(op),
      .in_a(a), .in_b(b), .busy(busy), .done(done),
      .result_lo(lo), .result_hi(hi), .zero(zero), .ovf(ovf), .div_by_zero(dbz)
   );

   alu_mc #(.WIDTH(8), .DEFAULT_RESULT(1000)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .alu_operation(op8),
      .in_a(a8), .in_b(b8), .busy(busy8), .done(done8),
      .result_lo(lo8), .result_hi(hi8), .zero(zero8), .ovf(ovf8), .div_by_zero(dbz8)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        z;
      logic        o;
      logic        d;
   } vec_t;

   vec_t vt [14];
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Returns the cycle (1 = first cycle after the start edge) in which done is seen
   task automatic wait_done(input bit inject, output int cyc);
      int busy_bad;
      busy_bad = 0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 100) begin
         if (busy !== 1'b1) busy_bad++;
         if (inject && cyc == 10) begin
            op = OP_ADD; a = 32'h1; b = 32'h2; start = 1'b1;
         end
         @(posedge clk);
         #1 start = 1'b0;
         cyc++;
      end
      check("busy_while_running", 64'(busy_bad), 64'd0);
      check("done_without_busy", 64'({done, busy}), 64'(2'b10));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      int ndone;

      vt[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0};
      vt[1]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0};
      vt[2]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{OP_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{4'hC,    32'h12345678, 32'h9ABCDEF0, 32'h000003E8, 32'h0, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{OP_AND,  32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 32'h0, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{OP_OR,   32'h000000F0, 32'h0F000000, 32'h0F0000F0, 32'h0, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{OP_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{OP_SRL,  32'h80000000, 32'h00000021, 32'h40000000, 32'h0, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0};
      vt[10] = '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0};
      vt[11] = '{OP_DIVU, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, 32'h9, 1'b0, 1'b0, 1'b1};
      vt[12] = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0};
      vt[13] = '{4'hF,    32'h00000000, 32'h00000000, 32'h000003E8, 32'h0, 1'b0, 1'b0, 1'b0};

      rst = 1'b0; start = 1'b0; op = 4'h0; a = '0; b = '0;
      start8 = 1'b0; op8 = 4'h0; a8 = '0; b8 = '0;

      // Reset values
      #12;
      check("reset_lo_hi", {lo, hi}, 64'h0);
      check("reset_flags", 64'({busy, done, zero, ovf, dbz}), 64'(5'b00100));
      check("reset8_flags", 64'({busy8, done8, zero8, ovf8, dbz8, lo8, hi8}), 64'({5'b00100, 16'h0}));
      @(negedge clk) rst = 1'b1;

      // Single-cycle vectors
      for (int i = 0; i < 14; i++) begin
         start_op(vt[i].op, vt[i].a, vt[i].b);
         check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vt[i].lo));
         check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vt[i].hi));
         check($sformatf("vec%0d_flags", i), 64'({busy, done, zero, ovf, dbz}),
               64'({1'b0, 1'b1, vt[i].z, vt[i].o, vt[i].d}));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_pulse_hold", i), 64'({done, lo}), 64'({1'b0, vt[i].lo}));
      end

      // MUL max*max with an ignored ADD start at cycle 10
      start_op(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check("mul_busy_after_start", 64'({busy, done}), 64'(2'b10));
      wait_done(1'b1, cyc);
      check("mul_latency", 64'(cyc), 64'd32);
      check("mul_result", {hi, lo}, 64'hFFFFFFFE_00000001);
      check("mul_flags", 64'({zero, ovf, dbz}), 64'(3'b000));
      @(posedge clk);
      #1;
      check("mul_add_ignored", 64'({done, busy, lo}), 64'({2'b00, 32'h00000001}));

      // DIVU 100/7, then divide by zero
      start_op(OP_DIVU, 32'd100, 32'd7);
      wait_done(1'b0, cyc);
      check("div_latency", 64'(cyc), 64'd32);
      check("div_result", {hi, lo}, {32'd2, 32'd14});
      check("div_flags", 64'({zero, dbz}), 64'(2'b00));
      start_op(OP_DIVU, 32'd9, 32'd0);
      check("divz_result", {hi, lo}, {32'd9, 32'hFFFFFFFF});
      check("divz_flags", 64'({done, busy, zero, dbz}), 64'(4'b1001));

      // Reset during a multiply
      start_op(OP_MUL, 32'd5, 32'd6);
      for (int k = 1; k < 12; k++) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      #1;
      check("midrst_lo_hi", {hi, lo}, 64'h0);
      check("midrst_flags", 64'({busy, done, zero, ovf, dbz}), 64'(5'b00100));
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) ndone++;
      end
      check("midrst_no_done", 64'(ndone), 64'd0);
      start_op(OP_MUL, 32'd3, 32'd4);
      wait_done(1'b0, cyc);
      check("postrst_mul_latency", 64'(cyc), 64'd32);
      check("postrst_mul_result", {hi, lo}, {32'd0, 32'd12});

      // WIDTH=8 back-to-back: MUL then AND accepted in the done cycle
      @(negedge clk);
      op8 = OP_MUL; a8 = 8'd15; b8 = 8'd17; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      cyc = 1;
      while (done8 !== 1'b1 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("w8_mul_latency", 64'(cyc), 64'd8);
      check("w8_mul_result", 64'({hi8, lo8}), 64'h00FF);
      check("w8_mul_flags", 64'({busy8, zero8}), 64'(2'b00));
      op8 = OP_AND; a8 = 8'hF0; b8 = 8'h3C; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      check("w8_and_result", 64'({done8, busy8, hi8, lo8}), 64'({2'b10, 8'h00, 8'h30}));
      @(negedge clk);
      op8 = 4'hB; a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      check("w8_default_trunc", 64'({done8, hi8, lo8}), 64'({1'b1, 8'h00, 8'hE8}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
